vm_agent_qdma_c2h_arbiter: RTL and testbench

- Shares the single QDMA C2H stream (card-to-host) among three requesters: Coyote host-memory path, VM agent and Coyote ISR/page-migration path.
- Arbitration is packet-granular and round-robin. Each packet is tagged with its source's QID. This is the egress counterpart of the H2C QID demux.
- Sits between the three producers and the QDMA m_axis_c2h input.

---
 rtl/vm_agent_qdma_pkg.sv | 25 ++
 rtl/vm_agent_rr_pick.sv | 26 ++
 rtl/vm_agent_qdma_c2h_arbiter.sv | 119 +++++++++++
 tb/tb_vm_agent_qdma_c2h_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/vm_agent_qdma_pkg.sv
// Shared constants, FSM state type and helpers for the QDMA C2H egress arbiter.
package vm_agent_qdma_pkg;

  localparam int NUM_SRC = 3;

  localparam logic [1:0] SRC_COYOTE = 2'd0;
  localparam logic [1:0] SRC_VM     = 2'd1;
  localparam logic [1:0] SRC_ISR    = 2'd2;
  localparam logic [1:0] GRANT_NONE = 2'd3;

  localparam int QID_COYOTE_DEF = 0;
  localparam int QID_VM_DEF     = 1;
  localparam int QID_ISR_DEF    = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  // Successor in the 0->1->2->0 ring; anything out of range restarts at 0.
  function automatic logic [1:0] next_src(input logic [1:0] s);
    return (s >= SRC_ISR) ? SRC_COYOTE : s + 2'd1;
  endfunction

endpackage

// File: rtl/vm_agent_rr_pick.sv
// Combinational round-robin picker: first asserted request after i_last.
module vm_agent_rr_pick
  import vm_agent_qdma_pkg::*;
(
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [1:0]         i_last,
  output logic [1:0]         o_win,
  output logic               o_found
);

  logic [1:0] w_cur;

  always_comb begin
    o_win   = SRC_COYOTE;
    o_found = 1'b0;
    w_cur   = next_src(i_last);
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!o_found && i_req[w_cur]) begin
        o_win   = w_cur;
        o_found = 1'b1;
      end
      w_cur = next_src(w_cur);
    end
  end

endmodule

// File: rtl/vm_agent_qdma_c2h_arbiter.sv
// Packet-granular arbiter sharing the QDMA C2H stream among coyote, vm_agent and isr.
// Build option VM_AGENT_C2H_ISR_PRIO_EN gives the isr source strict priority at arbitration.
module vm_agent_qdma_c2h_arbiter
  import vm_agent_qdma_pkg::*;
#(
  parameter int DATA_W     = 512,
  parameter int MTY_W      = 6,
  parameter int QID_COYOTE = QID_COYOTE_DEF,
  parameter int QID_VM     = QID_VM_DEF,
  parameter int QID_ISR    = QID_ISR_DEF,
  parameter int CNT_W      = 32
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [NUM_SRC*DATA_W-1:0]  s_axis_c2h_tdata,
  input  logic [NUM_SRC*MTY_W-1:0]   s_axis_c2h_tuser_mty,
  input  logic [NUM_SRC-1:0]         s_axis_c2h_tlast,
  input  logic [NUM_SRC-1:0]         s_axis_c2h_tvalid,
  output logic [NUM_SRC-1:0]         s_axis_c2h_tready,
  output logic [DATA_W-1:0]          qdma_axis_c2h_tdata,
  output logic [MTY_W-1:0]           qdma_axis_c2h_tuser_mty,
  output logic [10:0]                qdma_axis_c2h_tuser_qid,
  output logic                       qdma_axis_c2h_tlast,
  output logic                       qdma_axis_c2h_tvalid,
  input  logic                       qdma_axis_c2h_tready,
  output logic [1:0]                 grant_id,
  output logic [NUM_SRC*CNT_W-1:0]   pkt_cnt
);

  state_t                          r_state, w_state_nxt;
  logic [1:0]                      r_grant, r_last_grant;
  logic [NUM_SRC-1:0][CNT_W-1:0]   r_cnt;
  logic [1:0]                      w_win, w_rr_win, w_idx;
  logic                            w_found, w_rr_found, w_upd_last, w_pkt_done;

`ifdef VM_AGENT_C2H_ISR_PRIO_EN
  // isr wins outright; coyote and vm rotate between themselves and the
  // rotation pointer ignores isr grants so it is not disturbed by them.
  vm_agent_rr_pick u_pick (
    .i_req   (s_axis_c2h_tvalid & 3'b011),
    .i_last  (r_last_grant),
    .o_win   (w_rr_win),
    .o_found (w_rr_found)
  );
  assign w_win      = s_axis_c2h_tvalid[SRC_ISR] ? SRC_ISR : w_rr_win;
  assign w_found    = s_axis_c2h_tvalid[SRC_ISR] | w_rr_found;
  assign w_upd_last = (w_win != SRC_ISR);
`else
  vm_agent_rr_pick u_pick (
    .i_req   (s_axis_c2h_tvalid),
    .i_last  (r_last_grant),
    .o_win   (w_rr_win),
    .o_found (w_rr_found)
  );
  assign w_win      = w_rr_win;
  assign w_found    = w_rr_found;
  assign w_upd_last = 1'b1;
`endif

  // Keep the slice index in range while idle; outputs are gated anyway.
  assign w_idx      = (r_grant == GRANT_NONE) ? SRC_COYOTE : r_grant;
  assign w_pkt_done = (r_state == ST_XFER) && s_axis_c2h_tvalid[w_idx] &&
                      s_axis_c2h_tlast[w_idx] && qdma_axis_c2h_tready;

  always_comb begin
    w_state_nxt             = r_state;
    s_axis_c2h_tready       = '0;
    qdma_axis_c2h_tdata     = '0;
    qdma_axis_c2h_tuser_mty = '0;
    qdma_axis_c2h_tlast     = 1'b0;
    qdma_axis_c2h_tvalid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) w_state_nxt = ST_XFER;
      end
      ST_XFER: begin
        qdma_axis_c2h_tdata      = s_axis_c2h_tdata[w_idx*DATA_W +: DATA_W];
        qdma_axis_c2h_tuser_mty  = s_axis_c2h_tuser_mty[w_idx*MTY_W +: MTY_W];
        qdma_axis_c2h_tlast      = s_axis_c2h_tlast[w_idx];
        qdma_axis_c2h_tvalid     = s_axis_c2h_tvalid[w_idx];
        s_axis_c2h_tready[w_idx] = qdma_axis_c2h_tready;
        if (w_pkt_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    case (r_grant)
      SRC_COYOTE: qdma_axis_c2h_tuser_qid = 11'(QID_COYOTE);
      SRC_VM:     qdma_axis_c2h_tuser_qid = 11'(QID_VM);
      SRC_ISR:    qdma_axis_c2h_tuser_qid = 11'(QID_ISR);
      default:    qdma_axis_c2h_tuser_qid = '0;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state      <= ST_IDLE;
      r_grant      <= GRANT_NONE;
      r_last_grant <= SRC_ISR;
      r_cnt        <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_found) begin
        r_grant <= w_win;
        if (w_upd_last) r_last_grant <= w_win;
      end
      if (w_pkt_done) begin
        r_grant        <= GRANT_NONE;
        r_cnt[w_idx]   <= r_cnt[w_idx] + 1'b1;
      end
    end
  end

  assign grant_id = r_grant;
  assign pkt_cnt  = r_cnt;

endmodule

// File: tb/tb_vm_agent_qdma_c2h_arbiter.sv
// Randomized bench for the C2H arbiter against a packet-level ownership model.
module tb_vm_agent_qdma_c2h_arbiter;

  localparam int DW = 64;
  localparam int MW = 3;
  localparam int CW = 4;

  logic              aclk = 1'b0;
  logic              areset = 1'b1;
  logic [3*DW-1:0]   s_tdata = '0;
  logic [3*MW-1:0]   s_mty = '0;
  logic [2:0]        s_tlast = '0;
  logic [2:0]        s_tvalid = '0;
  logic [2:0]        s_tready;
  logic [DW-1:0]     q_tdata;
  logic [MW-1:0]     q_mty;
  logic [10:0]       q_qid;
  logic              q_tlast, q_tvalid;
  logic              q_tready = 1'b0;
  logic [1:0]        grant_id;
  logic [3*CW-1:0]   pkt_cnt;

  vm_agent_qdma_c2h_arbiter #(.DATA_W(DW), .MTY_W(MW), .CNT_W(CW)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_c2h_tdata(s_tdata), .s_axis_c2h_tuser_mty(s_mty),
    .s_axis_c2h_tlast(s_tlast), .s_axis_c2h_tvalid(s_tvalid),
    .s_axis_c2h_tready(s_tready),
    .qdma_axis_c2h_tdata(q_tdata), .qdma_axis_c2h_tuser_mty(q_mty),
    .qdma_axis_c2h_tuser_qid(q_qid), .qdma_axis_c2h_tlast(q_tlast),
    .qdma_axis_c2h_tvalid(q_tvalid), .qdma_axis_c2h_tready(q_tready),
    .grant_id(grant_id), .pkt_cnt(pkt_cnt)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: who owns the link (-1 = nobody), rotation pointer, per-source packet counts.
  int          owner;
  int          lastg;
  int          cnt [3];
  // Producers: packet length, beat position, current beat payload.
  int          len [3];
  int          beat [3];
  logic [DW-1:0] dat [3];
  logic [MW-1:0] mty [3];
  logic [2:0]  en;
  int          vprob, rprob;
  int          grants [$];

  function automatic int pick(input logic [2:0] v);
`ifdef VM_AGENT_C2H_ISR_PRIO_EN
    if (v[2]) return 2;
    for (int k = 1; k <= 3; k++) begin
      int s = (lastg + k) % 3;
      if (s != 2 && v[s]) return s;
    end
`else
    for (int k = 1; k <= 3; k++) begin
      int s = (lastg + k) % 3;
      if (v[s]) return s;
    end
`endif
    return -1;
  endfunction

  task automatic new_beat(input int i);
    dat[i] = {$urandom, $urandom};
    mty[i] = MW'($urandom);
  endtask

  task automatic new_pkt(input int i);
    len[i]  = $urandom_range(1, 4);
    beat[i] = 0;
    new_beat(i);
  endtask

  task automatic model_reset();
    owner = -1;
    lastg = 2;
    for (int i = 0; i < 3; i++) begin
      cnt[i] = 0;
      new_pkt(i);
    end
  endtask

  // One clock: drive, check at negedge, advance the model at posedge.
  task automatic step(input bit rst_now);
    logic [2:0] exp_rdy;
    logic       exp_v;
    int         w;
    areset = rst_now;
    for (int i = 0; i < 3; i++) begin
      s_tdata[i*DW +: DW] = dat[i];
      s_mty[i*MW +: MW]   = mty[i];
      s_tlast[i]          = (beat[i] == len[i] - 1);
      s_tvalid[i]         = en[i] && ($urandom_range(0, 99) < vprob);
    end
    q_tready = ($urandom_range(0, 99) < rprob);
    @(negedge aclk);
    exp_v   = (owner >= 0) ? s_tvalid[owner] : 1'b0;
    exp_rdy = (owner >= 0) ? 3'(q_tready) << owner : 3'b000;
    chk("grant_id", 64'(grant_id), (owner >= 0) ? 64'(owner) : 64'd3);
    chk("tvalid", 64'(q_tvalid), 64'(exp_v));
    chk("s_tready", 64'(s_tready), 64'(exp_rdy));
    chk("pkt_cnt", 64'(pkt_cnt), 64'({CW'(cnt[2]), CW'(cnt[1]), CW'(cnt[0])}));
    if (exp_v) begin
      chk("tdata", 64'(q_tdata), 64'(dat[owner]));
      chk("tlast", 64'(q_tlast), 64'(s_tlast[owner]));
      chk("qid", 64'(q_qid), 64'(owner));
      if (s_tlast[owner]) chk("mty", 64'(q_mty), 64'(mty[owner]));
    end
    @(posedge aclk);
    if (rst_now) begin
      model_reset();
    end else if (owner < 0) begin
      w = pick(s_tvalid);
      if (w >= 0) begin
        owner = w;
        grants.push_back(w);
`ifdef VM_AGENT_C2H_ISR_PRIO_EN
        if (w != 2) lastg = w;
`else
        lastg = w;
`endif
      end
    end else if (s_tvalid[owner] && q_tready) begin
      if (beat[owner] == len[owner] - 1) begin
        cnt[owner] = (cnt[owner] + 1) % (1 << CW);
        new_pkt(owner);
        owner = -1;
      end else begin
        beat[owner]++;
        new_beat(owner);
      end
    end
    #1;
  endtask

  task automatic phase(input logic [2:0] m, input int vp, input int rp, input int n);
    en = m; vprob = vp; rprob = rp;
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  initial begin
    bit did_rst;
    en = '0; vprob = 0; rprob = 0;
    model_reset();
    areset = 1'b1;
    repeat (2) @(posedge aclk);
    #1;

    phase(3'b000, 0, 100, 3);       // reset state, nothing requesting
    phase(3'b010, 100, 100, 20);    // lone vm source, bubble before each packet
    grants.delete();
    phase(3'b111, 100, 100, 40);    // all sources busy
    for (int i = 0; i < 4 && i < grants.size(); i++)
      chk("rr_order", 64'(grants[i]), 64'((i + 1 + grants[0]) % 3 == 0 ? 0 : 0) + 64'((grants[0] + i) % 3));
    grants.delete();
    phase(3'b101, 100, 100, 30);    // coyote vs isr
    if (grants.size() >= 2) begin
`ifdef VM_AGENT_C2H_ISR_PRIO_EN
      chk("isr_prio", 64'(grants[1]), 64'd2);
`else
      chk("alt_0_2", 64'(grants[1] + grants[0]), 64'd2);
`endif
    end
    phase(3'b001, 100, 50, 20);     // stalled downstream on a single source

    en = 3'b111; vprob = 70; rprob = 70;
    did_rst = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (!did_rst && i > 600 && owner >= 0 && beat[owner] > 0) begin
        step(1'b1);
        did_rst = 1'b1;
      end else begin
        step(1'b0);
      end
    end
    chk("mid_pkt_reset_hit", 64'(did_rst), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
